// File: rtl/alu_sequencer.sv
// Multi-cycle controller that runs short programs on the external 4-bit datapath.
// Optional single-step mode is enabled with ALU_SEQ_STEP_EN (adds port step and a HOLD state).
module alu_sequencer #(
    parameter int unsigned PROG_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PROG_AW:0]   count,
    output logic               busy,
    output logic               done,
    input  logic               prog_we,
    input  logic [PROG_AW-1:0] prog_addr,
    input  logic [8:0]         prog_data,
    input  logic               reg_we,
    input  logic [1:0]         reg_addr,
    input  logic [3:0]         reg_data,
    input  logic [1:0]         rdbk_addr,
    output logic [3:0]         rdbk_data,
    output logic [2:0]         alu_sel,
    output logic [3:0]         alu_rs,
    output logic [3:0]         alu_rt,
    input  logic [3:0]         alu_rd
`ifdef ALU_SEQ_STEP_EN
    ,
    input  logic               step
`endif
);

    localparam int unsigned CW    = PROG_AW + 1;
    localparam int unsigned DEPTH = 1 << PROG_AW;
    localparam logic [CW-1:0] MAX_CNT = CW'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef ALU_SEQ_STEP_EN
    localparam logic [2:0] S_HOLD  = 3'd4;
`endif

    logic [2:0]    state;
    logic [2:0]    nxt;
    logic [CW-1:0] pc;
    logic [CW-1:0] cnt;
    logic [8:0]    ir;
    logic [3:0]    rf  [4];
    logic [8:0]    mem [DEPTH];

    logic [CW-1:0] cnt_clamp_c;
    logic          last_c;

    assign cnt_clamp_c = (count > MAX_CNT) ? MAX_CNT : count;
    assign last_c      = (pc == cnt - CW'(1));
    assign rdbk_data   = rf[rdbk_addr];

    // Datapath operands are only presented while executing
    assign alu_sel = (state == S_EXEC) ? ir[8:6]     : 3'd0;
    assign alu_rs  = (state == S_EXEC) ? rf[ir[3:2]] : 4'd0;
    assign alu_rt  = (state == S_EXEC) ? rf[ir[1:0]] : 4'd0;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start) nxt = (cnt_clamp_c == '0) ? S_DONE : S_FETCH;
            S_FETCH: nxt = S_EXEC;
`ifdef ALU_SEQ_STEP_EN
            S_EXEC:  nxt = last_c ? S_DONE : S_HOLD;
            S_HOLD:  if (step) nxt = S_FETCH;
`else
            S_EXEC:  nxt = last_c ? S_DONE : S_FETCH;
`endif
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Reset has priority, so a write-back on the reset edge is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            cnt   <= '0;
            ir    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
        end else begin
            state <= nxt;
            busy  <= (nxt != S_IDLE);
            done  <= (nxt == S_DONE);
            if (state == S_IDLE && start) begin
                cnt <= cnt_clamp_c;
                pc  <= '0;
            end
            if (state == S_FETCH) ir <= mem[pc[PROG_AW-1:0]];
            if (state == S_EXEC) begin
                rf[ir[5:4]] <= alu_rd;
                pc          <= pc + CW'(1);
            end else if (state == S_IDLE && reg_we) begin
                rf[reg_addr] <= reg_data;
            end
        end
    end

    // Program memory keeps its contents across reset
    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE) mem[prog_addr] <= prog_data;
    end

endmodule
